falling_edge_detc: RTL and testbench



---
 rtl/falling_edge_detc.sv | 26 ++
 tb/tb_falling_edge_detc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/falling_edge_detc.sv
// Falling-edge detector: flags the cycle in which Test_Singal drops 1->0.
// Ports: ACLK, ARESETN (async low), Test_Singal (in), Falling (comb out).
module falling_edge_detc (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic Test_Singal,
  output logic Falling
);

  logic r_prev;
  logic w_fall;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= Test_Singal;
    end
  end

  // Unregistered so the strobe appears with zero latency;
  // reset clears r_prev, which forces the output low.
  assign w_fall  = r_prev & ~Test_Singal;
  assign Falling = w_fall;

endmodule

// File: tb/tb_falling_edge_detc.sv
// Directed bench for falling_edge_detc.
// One task per scenario; summary on one line.
module tb_falling_edge_detc;

  logic clk;
  logic rst_n;
  logic sig;
  logic fall;

  int checks;
  int errors;

  falling_edge_detc dut (
    .ACLK        (clk),
    .ARESETN     (rst_n),
    .Test_Singal (sig),
    .Falling     (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    sig   = 1'b1;
    #1;
    checks++;
    if (fall !== 1'b0) begin
      errors++;
      $display("FAIL reset_init got %b exp 0", fall);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (fall !== 1'b0) begin
        errors++;
        $display("FAIL reset_hi_%0d got %b exp 0", i, fall);
      end
      @(negedge clk);
      sig = 1'b0;
      #1;
      checks++;
      if (fall !== 1'b0) begin
        errors++;
        $display("FAIL reset_lo_%0d got %b exp 0", i, fall);
      end
      sig = 1'b1;
    end
    @(negedge clk);
    sig   = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (fall !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got %b exp 0", fall);
    end
  endtask

  task automatic test_stable_rise();
    sig = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (fall !== 1'b0) begin
        errors++;
        $display("FAIL stable_low_%0d got %b exp 0", i, fall);
      end
    end
    @(negedge clk);
    sig = 1'b1;
    #1;
    checks++;
    if (fall !== 1'b0) begin
      errors++;
      $display("FAIL rise_now got %b exp 0", fall);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (fall !== 1'b0) begin
        errors++;
        $display("FAIL stable_high_%0d got %b exp 0", i, fall);
      end
    end
  endtask

  task automatic test_single_fall();
    sig = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sig = 1'b0;
    #1;
    checks++;
    if (fall !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse got %b exp 1", fall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (fall !== 1'b0) begin
      errors++;
      $display("FAIL single_end got %b exp 0", fall);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      sig = 1'b1;
      #1;
      checks++;
      if (fall !== 1'b0) begin
        errors++;
        $display("FAIL b2b_high_%0d got %b exp 0", n, fall);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if (fall !== 1'b0) begin
        errors++;
        $display("FAIL b2b_held_%0d got %b exp 0", n, fall);
      end
      @(negedge clk);
      sig = 1'b0;
      #1;
      checks++;
      if (fall !== 1'b1) begin
        errors++;
        $display("FAIL b2b_pulse_%0d got %b exp 1", n, fall);
      end
      @(posedge clk);
      #1;
      checks++;
      if (fall !== 1'b0) begin
        errors++;
        $display("FAIL b2b_end_%0d got %b exp 0", n, fall);
      end
    end
  endtask

  task automatic test_glitch();
    sig = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sig = 1'b0;
    #1;
    checks++;
    if (fall !== 1'b1) begin
      errors++;
      $display("FAIL glitch_low got %b exp 1", fall);
    end
    #1;
    sig = 1'b1;
    #1;
    checks++;
    if (fall !== 1'b0) begin
      errors++;
      $display("FAIL glitch_back got %b exp 0", fall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (fall !== 1'b0) begin
      errors++;
      $display("FAIL glitch_edge got %b exp 0", fall);
    end
  endtask

  task automatic test_reset_mid_pulse();
    sig = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sig = 1'b0;
    #1;
    checks++;
    if (fall !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got %b exp 1", fall);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (fall !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got %b exp 0", fall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (fall !== 1'b0) begin
      errors++;
      $display("FAIL mid_release got %b exp 0", fall);
    end
    // detector works again after the reset
    @(negedge clk);
    sig = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sig = 1'b0;
    #1;
    checks++;
    if (fall !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_pulse got %b exp 1", fall);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    sig    = 1'b0;
    test_reset();
    test_stable_rise();
    test_single_fall();
    test_back_to_back();
    test_glitch();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
